// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control sequencer:
// opcode constants, immediate-format encodings and the FSM state type.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // True for the five opcode classes the sequencer knows how to execute.
    function automatic logic is_legal_op(input logic [6:0] opc);
        return (opc == OP_R) || (opc == OP_I) || (opc == OP_S) ||
               (opc == OP_L) || (opc == OP_B);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-wait watchdog. Counts cycles a request has been outstanding
// without ready and flags a timeout on the cycle the count sits at
// WAIT_MAX and ready is still low. Ready in that same cycle wins.
module ctrl_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] wait_cnt;

    // Wait counter: cleared when a request phase starts, saturates at WAIT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (active && !ready && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = active && !ready && (wait_cnt == CNT_MAX);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// strobes one phase at a time and owns the memory request handshakes.
// Outputs are decoded from registered state; only ir_load/pc_we in the
// fetch-ready cycle follow imem_ready combinationally.
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int OP_W     = 7,
    parameter int IMM_W    = 2,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_load,
    output logic             pc_we,
    output logic             pc_src,
    output logic [IMM_W-1:0] imm_sel,
    output logic             alu_src,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             busy,
    output logic             err
);

    state_t          state;
    state_t          state_next;
    logic            fetch_req;
    logic            fetch_req_next;
    logic [OP_W-1:0] op_q;

    logic timer_clear;
    logic timer_active;
    logic timer_ready;
    logic timeout;

    // The timer watches whichever request is currently outstanding.
    assign timer_active = ((state == ST_FETCH) && fetch_req) || (state == ST_MEM);
    assign timer_ready  = (state == ST_MEM) ? dmem_ready : imem_ready;
    assign timer_clear  = ((state == ST_FETCH) && !fetch_req && run_en) ||
                          ((state == ST_EXEC) && ((op_q == OP_S) || (op_q == OP_L)));

    ctrl_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .active  (timer_active),
        .ready   (timer_ready),
        .timeout (timeout)
    );

    // State register plus the fetch-issued flag that keeps imem_req up until ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            fetch_req <= 1'b0;
        end else begin
            state     <= state_next;
            fetch_req <= fetch_req_next;
        end
    end

    // Opcode is captured once in DECODE and used for the rest of the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if (state == ST_DECODE) begin
            op_q <= op;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next     = state;
        fetch_req_next = fetch_req;
        imem_req       = 1'b0;
        ir_load        = 1'b0;
        pc_we          = 1'b0;
        pc_src         = 1'b0;
        imm_sel        = IMM_W'(IMM_I);
        alu_src        = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        reg_we         = 1'b0;
        wb_sel         = 1'b0;
        err            = 1'b0;
        case (state)
            ST_FETCH: begin
                if (!fetch_req) begin
                    if (run_en) fetch_req_next = 1'b1;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_load        = 1'b1;
                        pc_we          = 1'b1;
                        fetch_req_next = 1'b0;
                        state_next     = ST_DECODE;
                    end else if (timeout) begin
                        fetch_req_next = 1'b0;
                        state_next     = ST_TRAP;
                    end
                end
            end
            ST_DECODE: begin
                state_next = is_legal_op(7'(op)) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (7'(op_q))
                    OP_R: state_next = ST_WB;
                    OP_I: begin
                        alu_src    = 1'b1;
                        state_next = ST_WB;
                    end
                    OP_S: begin
                        imm_sel    = IMM_W'(IMM_S);
                        alu_src    = 1'b1;
                        state_next = ST_MEM;
                    end
                    OP_L: begin
                        alu_src    = 1'b1;
                        state_next = ST_MEM;
                    end
                    OP_B: begin
                        imm_sel    = IMM_W'(IMM_B);
                        pc_src     = 1'b1;
                        pc_we      = zero;
                        state_next = ST_FETCH;
                    end
                    default: state_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (7'(op_q) == OP_S);
                if (dmem_ready) begin
                    state_next = (7'(op_q) == OP_S) ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_next = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                wb_sel     = (7'(op_q) != OP_L);
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                err = 1'b1;
            end
            default: state_next = ST_TRAP;
        endcase
    end

    assign busy = (state != ST_FETCH) || imem_req;

endmodule
